vga_tile_buffer: RTL

VGA_TILE_BUFFER -- requirements
Module: vga_tile_buffer

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_tile_buffer_if.sv | 27 ++
 rtl/vga_tile_ram.sv | 43 ++++
 rtl/vga_tile_buffer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the tile buffer: derived geometry and clear FSM encoding.
package vga_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int calc_data_width(int char_bits, int chars_per_word);
        return char_bits * chars_per_word;
    endfunction

    function automatic int calc_words_per_row(int h_tiles, int chars_per_word);
        return h_tiles / chars_per_word;
    endfunction

    function automatic int calc_num_addrs(int h_tiles, int v_tiles, int chars_per_word);
        return (h_tiles / chars_per_word) * v_tiles;
    endfunction

endpackage

// File: rtl/vga_tile_buffer_if.sv
// Write port plus host and display read ports of the tile RAM.
interface vga_tile_buffer_if #(
    parameter int AW     = 10,
    parameter int DW     = 28,
    parameter int STRB_W = 4
);
    logic              we;
    logic [AW-1:0]     waddr;
    logic [STRB_W-1:0] wstrb;
    logic [DW-1:0]     wdata;
    logic              r_req;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_data;
    logic              r_valid;
    logic [AW-1:0]     v_addr;
    logic [DW-1:0]     v_data;

    modport master (
        output we, waddr, wstrb, wdata, r_req, r_addr, v_addr,
        input  r_data, r_valid, v_data
    );

    modport slave (
        input  we, waddr, wstrb, wdata, r_req, r_addr, v_addr,
        output r_data, r_valid, v_data
    );
endinterface

// File: rtl/vga_tile_ram.sv
// Tile-strobed single-write, dual-read RAM; both reads are registered and see pre-write data.
module vga_tile_ram
    import vga_pkg::*;
#(
    parameter int CHAR_BITS      = 7,
    parameter int CHARS_PER_WORD = 4,
    parameter int NUM_ADDRS      = 600,
    parameter int ADDR_WIDTH     = 10,
    localparam int DATA_WIDTH    = calc_data_width(CHAR_BITS, CHARS_PER_WORD)
) (
    input logic clk,
    input logic rst,
    vga_tile_buffer_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDRS - 1);

    logic [DATA_WIDTH-1:0] mem [NUM_ADDRS] = '{default: '0};

    // Caller guarantees waddr is in range whenever we is set.
    always_ff @(posedge clk) begin
        if (bus.we) begin
            for (int k = 0; k < CHARS_PER_WORD; k++) begin
                if (bus.wstrb[k])
                    mem[bus.waddr][k*CHAR_BITS +: CHAR_BITS] <= bus.wdata[k*CHAR_BITS +: CHAR_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.r_data  <= '0;
            bus.r_valid <= 1'b0;
            bus.v_data  <= '0;
        end else begin
            bus.r_valid <= bus.r_req;
            if (bus.r_req)
                bus.r_data <= (bus.r_addr <= LAST_ADDR) ? mem[bus.r_addr] : '0;
            bus.v_data <= (bus.v_addr <= LAST_ADDR) ? mem[bus.v_addr] : '0;
        end
    end

endmodule

// File: rtl/vga_tile_buffer.sv
// Text-mode tile buffer: host write/read, scrolled display read, and a bulk clear engine.
module vga_tile_buffer
    import vga_pkg::*;
#(
    parameter int H_TILES          = 80,
    parameter int V_TILES          = 30,
    parameter int CHAR_BITS        = 7,
    parameter int CHARS_PER_WORD   = 4,
    parameter int C_AXI_DATA_WIDTH = 32,
    localparam int DATA_WIDTH      = calc_data_width(CHAR_BITS, CHARS_PER_WORD),
    localparam int WORDS_PER_ROW   = calc_words_per_row(H_TILES, CHARS_PER_WORD),
    localparam int NUM_ADDRS       = calc_num_addrs(H_TILES, V_TILES, CHARS_PER_WORD),
    localparam int ADDR_WIDTH      = $clog2(NUM_ADDRS),
    localparam int ROW_WIDTH       = $clog2(V_TILES),
    localparam int STRB_WIDTH      = C_AXI_DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] w_addr_i,
    input  logic [STRB_WIDTH-1:0] w_strb_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  r_req_i,
    input  logic [ADDR_WIDTH-1:0] r_addr_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  r_valid_o,
    input  logic [ADDR_WIDTH-1:0] vr_addr_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    input  logic                  frame_start_i,
    input  logic [ROW_WIDTH-1:0]  scroll_row_i,
    input  logic                  clr_req_i,
    input  logic [CHAR_BITS-1:0]  fill_i,
    output logic                  clr_busy_o
);

    if ((H_TILES % CHARS_PER_WORD) != 0 || CHARS_PER_WORD > STRB_WIDTH) begin : g_param_check
        $error("vga_tile_buffer: H_TILES must be a multiple of CHARS_PER_WORD that fits the strobe");
    end

    localparam int SUM_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDRS - 1);
    localparam logic [SUM_WIDTH-1:0]  NUM_SUM   = SUM_WIDTH'(NUM_ADDRS);
    localparam logic [ROW_WIDTH-1:0]  LAST_ROW  = ROW_WIDTH'(V_TILES - 1);

    clr_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_nxt;
    logic [CHAR_BITS-1:0]  fill_q, fill_nxt;
    logic [ADDR_WIDTH-1:0] scroll_off;
    logic [ROW_WIDTH-1:0]  row_sat;
    logic [SUM_WIDTH-1:0]  phys_sum;
    logic [ADDR_WIDTH-1:0] phys;
    logic                  busy;

    vga_tile_buffer_if #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .STRB_W(CHARS_PER_WORD)) ram_bus ();

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            clr_ptr <= '0;
            fill_q  <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
            fill_q  <= fill_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        fill_nxt    = fill_q;
        case (state)
            IDLE: begin
                if (clr_req_i) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                    fill_nxt    = fill_i;
                end
            end
            CLEAR: begin
                clr_ptr_nxt = clr_ptr + ADDR_WIDTH'(1);
                if (clr_ptr == LAST_ADDR) begin
                    state_nxt   = IDLE;
                    clr_ptr_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state == CLEAR);
    assign clr_busy_o = busy;

    // Offset only moves on frame boundaries so a frame never tears mid-scan.
    assign row_sat = (scroll_row_i > LAST_ROW) ? LAST_ROW : scroll_row_i;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            scroll_off <= '0;
        else if (frame_start_i)
            scroll_off <= ADDR_WIDTH'(int'(row_sat) * WORDS_PER_ROW);
    end

    assign phys_sum = {1'b0, vr_addr_i} + {1'b0, scroll_off};
    assign phys     = (phys_sum >= NUM_SUM) ? ADDR_WIDTH'(phys_sum - NUM_SUM)
                                            : phys_sum[ADDR_WIDTH-1:0];

    // The clear engine owns the write port; host writes are dropped while it runs.
    assign ram_bus.we     = !rst_i && (busy || (wr_en_i && (w_addr_i <= LAST_ADDR)));
    assign ram_bus.waddr  = busy ? clr_ptr : w_addr_i;
    assign ram_bus.wstrb  = busy ? '1 : w_strb_i[CHARS_PER_WORD-1:0];
    assign ram_bus.wdata  = busy ? {CHARS_PER_WORD{fill_q}} : din_i;
    assign ram_bus.r_req  = r_req_i;
    assign ram_bus.r_addr = r_addr_i;
    assign ram_bus.v_addr = phys;

    assign r_data_o  = ram_bus.r_data;
    assign r_valid_o = ram_bus.r_valid;
    assign dout_o    = ram_bus.v_data;

    vga_tile_ram #(
        .CHAR_BITS     (CHAR_BITS),
        .CHARS_PER_WORD(CHARS_PER_WORD),
        .NUM_ADDRS     (NUM_ADDRS),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_ram (
        .clk(clk_i),
        .rst(rst_i),
        .bus(ram_bus.slave)
    );

endmodule
